// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: bundles the CPU-side request/response and RAM-side signals
// of the memory sequencer.
//   CPU side : cpu_req, cpu_write, cpu_dw, cpu_address, cpu_wdata (to sequencer)
//              cpu_ack, cpu_rdata, busy                           (from sequencer)
//   RAM side : mem_address, mem_write_en, mem_data_out            (from sequencer)
//              mem_data_in                                        (to sequencer)
// Bit numbering: the big-endian fields [15:31] / [0:63] / [0:31] map to the
// descending vectors below, so address bit 31 is bit 0 here and data bits
// [0:31] of a doubleword are the upper half [63:32].
// Modports: master = CPU/RAM environment, slave = the sequencer.
interface mem_sequencer_if;
  logic        cpu_req;
  logic        cpu_write;
  logic        cpu_dw;
  logic [16:0] cpu_address;
  logic [63:0] cpu_wdata;
  logic        cpu_ack;
  logic [63:0] cpu_rdata;
  logic        busy;
  logic [16:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;

  modport master (
    output cpu_req, cpu_write, cpu_dw, cpu_address, cpu_wdata, mem_data_in,
    input  cpu_ack, cpu_rdata, busy, mem_address, mem_write_en, mem_data_out
  );

  modport slave (
    input  cpu_req, cpu_write, cpu_dw, cpu_address, cpu_wdata, mem_data_in,
    output cpu_ack, cpu_rdata, busy, mem_address, mem_write_en, mem_data_out
  );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: turns a single CPU word/doubleword request into one or two
// 32-bit RAM word accesses, each held for WAIT_STATES+1 cycles.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high
//   bus   - mem_sequencer_if.slave (CPU request/response + RAM port)
// Parameter WAIT_STATES: extra cycles per RAM word access, 0..15.
module mem_sequencer #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clock,
  input  logic reset,
  mem_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  state_t      state_q,  state_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic        write_q,  write_d;
  logic        dw_q,     dw_d;
  logic [16:0] addr_q,   addr_d;
  logic [63:0] wdata_q,  wdata_d;
  logic [63:0] rdata_q,  rdata_d;

  logic        ack_c;
  logic        we_c;
  logic [16:0] maddr_c;
  logic [31:0] mdout_c;
  logic        last_c;

  // Last cycle of an access state is the one where the wait counter hits 0.
  assign last_c = (cnt_q == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      dw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      dw_q    <= dw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    dw_d    = dw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_c   = 1'b0;
    we_c    = 1'b0;
    maddr_c = addr_q;
    mdout_c = 32'd0;

    unique case (state_q)
      IDLE: begin
        // RAM address follows the CPU so a read can start without a bubble.
        maddr_c = bus.cpu_address;
        if (bus.cpu_req) begin
          write_d = bus.cpu_write;
          dw_d    = bus.cpu_dw;
          addr_d  = bus.cpu_address;
          wdata_d = bus.cpu_wdata;
          cnt_d   = WAIT_LD;
          state_d = ACC0;
        end
      end

      ACC0: begin
        // Doubleword always starts at the even word of the pair.
        maddr_c = dw_q ? {addr_q[16:1], 1'b0} : addr_q;
        mdout_c = dw_q ? wdata_q[63:32] : wdata_q[31:0];
        we_c    = write_q && last_c;
        if (!last_c) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!write_q) begin
            if (dw_q) rdata_d[63:32] = bus.mem_data_in;
            else      rdata_d        = {32'd0, bus.mem_data_in};
          end
          if (dw_q) begin
            cnt_d   = WAIT_LD;
            state_d = ACC1;
          end else begin
            state_d = DONE;
          end
        end
      end

      ACC1: begin
        maddr_c = {addr_q[16:1], 1'b1};
        mdout_c = wdata_q[31:0];
        we_c    = write_q && last_c;
        if (!last_c) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!write_q) rdata_d[31:0] = bus.mem_data_in;
          state_d = DONE;
        end
      end

      DONE: begin
        ack_c   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_ack      = ack_c;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.mem_address  = maddr_c;
  assign bus.mem_write_en = we_c;
  assign bus.mem_data_out = mdout_c;

endmodule
